cascaded_pulse_seq: RTL

- Parametrised, single-clock successor to the fixed frame/pixel/laser/spad pulse chain.
- Provides `NUM_CH` identical pulse-train channels, each with:
  - a programmable start delay, period, high time and pulse count;
  - one-shot or continuous mode;
  - a trigger that is either the external trigger or the rising edge of the previous channel's output, so any cascade depth is built from configuration.
- Sits between the UART/register configuration block and the laser/SPAD pins.
- The IDELAY fine-delay stage stays downstream of this block.

---
 rtl/cascaded_pulse_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/cascaded_pulse_seq.sv
`timescale 1ns/1ps
// cascaded_pulse_seq: NUM_CH programmable pulse-train channels, each triggered by ext_trig or by the rising edge of the previous channel.
// Latency: trigger sampled at edge T -> busy from T+1, first pulse at T+1+start; each cascade hop adds one cycle.
// Backpressure: none; triggers while busy are dropped, abort or enable-low returns a channel to idle next cycle.
//
// Ports: clk_500m / reset (synchronous, active-high); ext_trig and abort are shared by all channels;
// ch_enable / ch_src / ch_continuous and the flattened ch_nums / ch_start / ch_period / ch_duty
// carry per-channel config; ch_out / ch_busy / ch_done / ch_cfg_err report per-channel status.
module cascaded_pulse_seq #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int TIME_W = 32,
    parameter int DUTY_W = 16
) (
    input  logic                     clk_500m,
    input  logic                     reset,
    input  logic                     ext_trig,
    input  logic                     abort,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic [NUM_CH-1:0]        ch_src,
    input  logic [NUM_CH-1:0]        ch_continuous,
    input  logic [NUM_CH*CNT_W-1:0]  ch_nums,
    input  logic [NUM_CH*TIME_W-1:0] ch_start,
    input  logic [NUM_CH*TIME_W-1:0] ch_period,
    input  logic [NUM_CH*DUTY_W-1:0] ch_duty,
    output logic [NUM_CH-1:0]        ch_out,
    output logic [NUM_CH-1:0]        ch_busy,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Channel 0 always listens to ext_trig, so its source select is a don't-care.
    logic unused_src0;
    assign unused_src0 = ch_src[0];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        // Trigger source and edge detect.
        logic src;
        logic trig_edge;
        if (gi == 0) begin : g_src0
            assign src = ext_trig;
        end else begin : g_srcn
            assign src = ch_src[gi] ? ch_out[gi-1] : ext_trig;
        end

        // Live configuration for this channel; duty is widened so it compares against phase directly.
        logic [CNT_W-1:0]  cfg_nums;
        logic [TIME_W-1:0] cfg_start;
        logic [TIME_W-1:0] cfg_period;
        logic [TIME_W-1:0] cfg_duty;
        logic              cfg_bad;

        assign cfg_nums   = ch_nums[gi*CNT_W +: CNT_W];
        assign cfg_start  = ch_start[gi*TIME_W +: TIME_W];
        assign cfg_period = ch_period[gi*TIME_W +: TIME_W];
        assign cfg_duty   = TIME_W'(ch_duty[gi*DUTY_W +: DUTY_W]);
        assign cfg_bad    = (cfg_period == '0) || (cfg_nums == '0) || (cfg_duty > cfg_period);

        state_t            state_q, state_d;
        logic [TIME_W-1:0] dly_q, dly_d;
        logic [TIME_W-1:0] phase_q, phase_d;
        logic [CNT_W-1:0]  pulse_q, pulse_d;
        logic [TIME_W-1:0] start_q, start_d;
        logic [TIME_W-1:0] period_q, period_d;
        logic [TIME_W-1:0] duty_q, duty_d;
        logic [CNT_W-1:0]  nums_q, nums_d;
        logic              cont_q, cont_d;
        logic              out_q, out_d;
        logic              done_q, done_d;
        logic              err_q, err_d;
        logic              src_prev_q, src_prev_d;

        assign trig_edge = src & ~src_prev_q;

        always_comb begin
            state_d    = state_q;
            dly_d      = dly_q;
            phase_d    = phase_q;
            pulse_d    = pulse_q;
            start_d    = start_q;
            period_d   = period_q;
            duty_d     = duty_q;
            nums_d     = nums_q;
            cont_d     = cont_q;
            err_d      = err_q;
            done_d     = 1'b0;
            src_prev_d = src;

            if (abort || ((state_q != ST_IDLE) && !ch_enable[gi])) begin
                // Abort wins over a simultaneous trigger; no done, error flag untouched.
                state_d = ST_IDLE;
                dly_d   = '0;
                phase_d = '0;
                pulse_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (trig_edge && ch_enable[gi]) begin
                            if (cfg_bad) begin
                                err_d = 1'b1;
                            end else begin
                                err_d    = 1'b0;
                                start_d  = cfg_start;
                                period_d = cfg_period;
                                duty_d   = cfg_duty;
                                nums_d   = cfg_nums;
                                cont_d   = ch_continuous[gi];
                                dly_d    = '0;
                                phase_d  = '0;
                                pulse_d  = '0;
                                // Zero start delay skips DELAY so the first pulse lands at T+1.
                                state_d  = (cfg_start == '0) ? ST_RUN : ST_DELAY;
                            end
                        end
                    end
                    ST_DELAY: begin
                        // DELAY occupies exactly start_q cycles (T+1 .. T+start).
                        if (dly_q == start_q - TIME_W'(1)) begin
                            state_d = ST_RUN;
                            dly_d   = '0;
                            phase_d = '0;
                            pulse_d = '0;
                        end else begin
                            dly_d = dly_q + TIME_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (phase_q == period_q - TIME_W'(1)) begin
                            phase_d = '0;
                            if (pulse_q == nums_q - CNT_W'(1)) begin
                                pulse_d = '0;
                                if (!cont_q) begin
                                    state_d = ST_IDLE;
                                    done_d  = 1'b1;
                                end
                            end else begin
                                pulse_d = pulse_q + CNT_W'(1);
                            end
                        end else begin
                            phase_d = phase_q + TIME_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            // Output is registered from next-state values so it lines up with the RUN phase it describes.
            out_d = (state_d == ST_RUN) && (phase_d < duty_d);
        end

        always_ff @(posedge clk_500m) begin
            if (reset) begin
                state_q    <= ST_IDLE;
                dly_q      <= '0;
                phase_q    <= '0;
                pulse_q    <= '0;
                start_q    <= '0;
                period_q   <= '0;
                duty_q     <= '0;
                nums_q     <= '0;
                cont_q     <= 1'b0;
                out_q      <= 1'b0;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
                // Track the source during reset so a level already high at release is not an edge.
                src_prev_q <= src;
            end else begin
                state_q    <= state_d;
                dly_q      <= dly_d;
                phase_q    <= phase_d;
                pulse_q    <= pulse_d;
                start_q    <= start_d;
                period_q   <= period_d;
                duty_q     <= duty_d;
                nums_q     <= nums_d;
                cont_q     <= cont_d;
                out_q      <= out_d;
                done_q     <= done_d;
                err_q      <= err_d;
                src_prev_q <= src_prev_d;
            end
        end

        assign ch_out[gi]     = out_q;
        assign ch_busy[gi]    = (state_q != ST_IDLE);
        assign ch_done[gi]    = done_q;
        assign ch_cfg_err[gi] = err_q;
    end

endmodule
